// File: rtl/fir_sm_fifo.sv
// First-word-fall-through AXI-Stream result buffer behind fir_top's sm_* master.
// Carries tlast, reports occupancy and tracks per-frame output beat counts.
module fir_sm_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          in_clr,
    input  logic                          in_s_tvalid,
    input  logic signed [pDATA_WIDTH-1:0] in_s_tdata,
    input  logic                          in_s_tlast,
    output logic                          out_s_tready,
    output logic                          out_m_tvalid,
    output logic signed [pDATA_WIDTH-1:0] out_m_tdata,
    output logic                          out_m_tlast,
    input  logic                          in_m_tready,
    output logic [ADDR_W:0]               out_level,
    output logic [31:0]                   out_beat_cnt,
    output logic [31:0]                   out_last_frame_len,
    output logic                          out_frame_done
);

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);

    // Each entry stores {tlast, tdata}.
    logic [pDATA_WIDTH:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      level;
    logic                 push;
    logic                 pop;

    // Flow control comes only from the registered level, so there is no
    // combinational path from in_m_tready back to out_s_tready.
    assign out_s_tready = (level != LVL_FULL);
    assign out_m_tvalid = (level != '0);
    assign out_level    = level;

    assign push = in_s_tvalid & out_s_tready & ~in_clr;
    assign pop  = out_m_tvalid & in_m_tready & ~in_clr;

    assign out_m_tlast = mem[rd_ptr][pDATA_WIDTH];
    assign out_m_tdata = mem[rd_ptr][pDATA_WIDTH-1:0];

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {in_s_tlast, in_s_tdata};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (in_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Frame accounting follows beats leaving the buffer, not entering it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_beat_cnt       <= '0;
            out_last_frame_len <= '0;
            out_frame_done     <= 1'b0;
        end else if (in_clr) begin
            out_beat_cnt   <= '0;
            out_frame_done <= 1'b0;
        end else if (pop && out_m_tlast) begin
            out_last_frame_len <= out_beat_cnt + 32'd1;
            out_beat_cnt       <= '0;
            out_frame_done     <= 1'b1;
        end else begin
            if (pop) begin
                out_beat_cnt <= out_beat_cnt + 32'd1;
            end
            out_frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Scoreboard bench for fir_sm_fifo: accepted beats are queued, a negedge
// monitor pops and compares every beat the buffer hands downstream.
module tb_fir_sm_fifo;

    logic               aclk;
    logic               aresetn;
    logic               in_clr;
    logic               in_s_tvalid;
    logic signed [31:0] in_s_tdata;
    logic               in_s_tlast;
    logic               out_s_tready;
    logic               out_m_tvalid;
    logic signed [31:0] out_m_tdata;
    logic               out_m_tlast;
    logic               in_m_tready;
    logic [4:0]         out_level;
    logic [31:0]        out_beat_cnt;
    logic [31:0]        out_last_frame_len;
    logic               out_frame_done;

    fir_sm_fifo #(.pDATA_WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .in_clr             (in_clr),
        .in_s_tvalid        (in_s_tvalid),
        .in_s_tdata         (in_s_tdata),
        .in_s_tlast         (in_s_tlast),
        .out_s_tready       (out_s_tready),
        .out_m_tvalid       (out_m_tvalid),
        .out_m_tdata        (out_m_tdata),
        .out_m_tlast        (out_m_tlast),
        .in_m_tready        (in_m_tready),
        .out_level          (out_level),
        .out_beat_cnt       (out_beat_cnt),
        .out_last_frame_len (out_last_frame_len),
        .out_frame_done     (out_frame_done)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cyc = 0;
    int          done_dbl = 0;
    logic        done_prev = 1'b0;
    logic [4:0]  lvl_max = '0;
    logic        rnd_en = 1'b0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compare every downstream handshake against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && !in_clr && out_m_tvalid && in_m_tready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h, expected no beat", {out_m_tlast, out_m_tdata});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_m_tlast, out_m_tdata} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h, expected %h", {out_m_tlast, out_m_tdata}, mon_exp);
                end
            end
        end
        if (out_frame_done) begin
            done_cyc++;
            if (done_prev) done_dbl++;
        end
        done_prev = out_frame_done;
        if (out_level > lvl_max) lvl_max = out_level;
    end

    // Entered and left just after a rising edge; holds the beat until accepted.
    task automatic push_beat(input logic [31:0] d, input logic l);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_s_tvalid = 1'b1;
        in_s_tdata  = d;
        in_s_tlast  = l;
        while (!acc && n < 300) begin
            if (rnd_en) in_m_tready = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            if (out_s_tready) begin
                exp_q.push_back({l, d});
                acc = 1'b1;
            end
            @(posedge aclk);
            #1;
            n++;
        end
        in_s_tvalid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got no acceptance, expected out_s_tready within 300 cycles");
        end
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            if (rnd_en) in_m_tready = ($urandom_range(0, 3) != 0);
            @(posedge aclk);
            #1;
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats left, expected 0", exp_q.size());
        end
    endtask

    int done_base;

    initial begin
        aresetn     = 1'b0;
        in_clr      = 1'b0;
        in_s_tvalid = 1'b0;
        in_s_tdata  = '0;
        in_s_tlast  = 1'b0;
        in_m_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_tvalid", 64'(out_m_tvalid), 64'd0);
        chk("rst_level", 64'(out_level), 64'd0);
        chk("rst_tready", 64'(out_s_tready), 64'd1);
        chk("rst_beat_cnt", 64'(out_beat_cnt), 64'd0);
        chk("rst_last_len", 64'(out_last_frame_len), 64'd0);
        chk("rst_done", 64'(out_frame_done), 64'd0);
        @(posedge aclk);
        #1;

        // 1: streaming with downstream always ready
        lvl_max = '0;
        done_base = done_cyc;
        in_m_tready = 1'b1;
        in_s_tvalid = 1'b1;
        in_s_tdata  = 32'd1;
        in_s_tlast  = 1'b0;
        @(negedge aclk);
        chk("t1_no_bypass", 64'(out_m_tvalid), 64'd0);
        chk("t1_tready", 64'(out_s_tready), 64'd1);
        exp_q.push_back({1'b0, 32'd1});
        @(posedge aclk);
        #1;
        for (int i = 2; i <= 5; i++) push_beat(32'(i), (i == 5));
        drain(20);
        repeat (2) @(negedge aclk);
        chk("t1_level_max", 64'(lvl_max), 64'd1);
        chk("t1_last_len", 64'(out_last_frame_len), 64'd5);
        chk("t1_beat_cnt", 64'(out_beat_cnt), 64'd0);
        chk("t1_done_pulses", 64'(done_cyc - done_base), 64'd1);
        @(posedge aclk);
        #1;

        // 2 + 3: fill, hold at full, pop-at-full, refill, release
        in_m_tready = 1'b0;
        done_base = done_cyc;
        for (int i = 0; i < 16; i++) push_beat(32'(100 + i), 1'b0);
        @(negedge aclk);
        chk("t2_full_level", 64'(out_level), 64'd16);
        chk("t2_full_tready", 64'(out_s_tready), 64'd0);
        @(posedge aclk);
        #1;
        in_s_tvalid = 1'b1;
        in_s_tdata  = 32'd116;
        in_s_tlast  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("t2_held_level", 64'(out_level), 64'd16);
        chk("t2_held_tready", 64'(out_s_tready), 64'd0);
        chk("t2_head_stable", 64'(out_m_tdata), 64'd100);
        @(posedge aclk);
        #1;
        in_m_tready = 1'b1;
        @(negedge aclk);
        chk("t3_full_pop_tready", 64'(out_s_tready), 64'd0);
        @(posedge aclk);
        #1;
        in_m_tready = 1'b0;
        @(negedge aclk);
        chk("t3_level_after_pop", 64'(out_level), 64'd15);
        chk("t3_tready_next", 64'(out_s_tready), 64'd1);
        if (out_s_tready) exp_q.push_back({1'b0, 32'd116});
        @(posedge aclk);
        #1;
        in_s_tvalid = 1'b0;
        @(negedge aclk);
        chk("t3_refilled", 64'(out_level), 64'd16);
        @(posedge aclk);
        #1;
        in_m_tready = 1'b1;
        for (int i = 17; i <= 19; i++) push_beat(32'(100 + i), (i == 19));
        drain(60);
        repeat (2) @(negedge aclk);
        chk("t2_drained_level", 64'(out_level), 64'd0);
        chk("t2_last_len", 64'(out_last_frame_len), 64'd20);
        chk("t2_done_pulses", 64'(done_cyc - done_base), 64'd1);
        @(posedge aclk);
        #1;

        // 4: long frame with random downstream stalls
        done_base = done_cyc;
        rnd_en = 1'b1;
        for (int i = 1; i <= 600; i++) push_beat(32'(i * 37 - 5000), (i == 600));
        drain(2000);
        rnd_en = 1'b0;
        in_m_tready = 1'b0;
        repeat (2) @(negedge aclk);
        chk("t4_last_len", 64'(out_last_frame_len), 64'd600);
        chk("t4_beat_cnt", 64'(out_beat_cnt), 64'd0);
        chk("t4_done_pulses", 64'(done_cyc - done_base), 64'd1);
        chk("t4_done_width", 64'(done_dbl), 64'd0);
        @(posedge aclk);
        #1;

        // 5: synchronous clear with beats buffered
        for (int i = 0; i < 5; i++) push_beat(32'(7 + i), 1'b0);
        in_m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        in_m_tready = 1'b0;
        @(negedge aclk);
        chk("t5_pre_level", 64'(out_level), 64'd3);
        chk("t5_pre_beat_cnt", 64'(out_beat_cnt), 64'd2);
        @(posedge aclk);
        #1;
        in_clr      = 1'b1;
        in_s_tvalid = 1'b1;
        in_s_tdata  = 32'h0000_dead;
        in_s_tlast  = 1'b0;
        @(negedge aclk);
        chk("t5_clr_tready", 64'(out_s_tready), 64'd1);
        exp_q.delete();
        @(posedge aclk);
        #1;
        in_clr      = 1'b0;
        in_s_tvalid = 1'b0;
        @(negedge aclk);
        chk("t5_tvalid", 64'(out_m_tvalid), 64'd0);
        chk("t5_level", 64'(out_level), 64'd0);
        chk("t5_beat_cnt", 64'(out_beat_cnt), 64'd0);
        chk("t5_last_len_kept", 64'(out_last_frame_len), 64'd600);
        @(posedge aclk);
        #1;
        in_m_tready = 1'b1;
        push_beat(32'd85, 1'b1);
        drain(20);
        repeat (2) @(negedge aclk);
        chk("t5_last_len", 64'(out_last_frame_len), 64'd1);
        @(posedge aclk);
        #1;

        // 6: asynchronous reset mid-frame
        in_m_tready = 1'b0;
        for (int i = 0; i < 9; i++) push_beat(32'(200 + i), 1'b0);
        in_m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        in_m_tready = 1'b0;
        @(negedge aclk);
        chk("t6_pre_level", 64'(out_level), 64'd7);
        chk("t6_pre_beat_cnt", 64'(out_beat_cnt), 64'd2);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(out_m_tvalid), 64'd0);
        chk("t6_rst_level", 64'(out_level), 64'd0);
        chk("t6_rst_beat_cnt", 64'(out_beat_cnt), 64'd0);
        chk("t6_rst_last_len", 64'(out_last_frame_len), 64'd0);
        exp_q.delete();
        @(posedge aclk);
        #1 aresetn = 1'b1;
        in_m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) push_beat(32'(300 + i), (i == 4));
        drain(20);
        repeat (2) @(negedge aclk);
        chk("t6_last_len", 64'(out_last_frame_len), 64'd4);
        chk("t6_beat_cnt", 64'(out_beat_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
